lutram_access_ctrl: RTL and testbench

LUTRAM_ACCESS_CTRL -- requirements
Module: lutram_access_ctrl

---
 rtl/lutram_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_lutram_access_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lutram_access_ctrl.sv
// LUTRAM access controller: clears the array after reset, then serves reads and
// posted writes through a small FIFO write buffer with read-after-write forwarding.
module lutram_access_ctrl #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS                 = 64,
    parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
    parameter int WRITE_BUFFER_DEPTH          = 4
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    input  logic                                         req_valid_in,
    output logic                                         req_ready_out,
    input  logic                                         req_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]             req_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]       req_data_in,
    output logic                                         resp_valid_out,
    input  logic                                         resp_ready_in,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]       resp_data_out,
    output logic                                         lutram_access_en_out,
    output logic                                         lutram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]             lutram_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]       lutram_write_element_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]       lutram_read_element_in,
    output logic                                         init_done_out,
    output logic [$clog2(WRITE_BUFFER_DEPTH+1)-1:0]      wb_count_out
);

    localparam int CNT_W = $clog2(WRITE_BUFFER_DEPTH + 1);
    localparam int AW    = SET_PTR_WIDTH_IN_BITS;
    localparam int DW    = SINGLE_ELEMENT_SIZE_IN_BITS;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [AW-1:0]    LAST_SET = AW'(NUMBER_SETS - 1);
    localparam logic [CNT_W-1:0] WB_FULL  = CNT_W'(WRITE_BUFFER_DEPTH);

    logic [0:0]       state;
    logic [AW-1:0]    init_ptr;
    logic [CNT_W-1:0] wb_count;
    logic [CNT_W-1:0] push_idx;

    // Entry 0 is always the oldest; younger entries sit at higher indices.
    logic [AW-1:0] wb_addr [WRITE_BUFFER_DEPTH];
    logic [DW-1:0] wb_data [WRITE_BUFFER_DEPTH];

    logic          in_run;
    logic          resp_stall;
    logic          req_accept;
    logic          rd_accept;
    logic          wr_accept;
    logic          wb_pop;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign in_run        = (state == ST_RUN);
    assign resp_stall    = resp_valid_out && !resp_ready_in;
    assign req_ready_out = in_run && (wb_count < WB_FULL) && !resp_stall;
    assign req_accept    = req_valid_in && req_ready_out;
    assign rd_accept     = req_accept && !req_write_in;
    assign wr_accept     = req_accept && req_write_in;
    assign wb_pop        = in_run && !rd_accept && (wb_count != '0);
    assign push_idx      = wb_pop ? (wb_count - CNT_W'(1)) : wb_count;
    assign init_done_out = in_run;
    assign wb_count_out  = wb_count;

    // Youngest matching entry wins, so later indices override earlier hits.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WRITE_BUFFER_DEPTH; i++) begin
            if ((CNT_W'(i) < wb_count) && (wb_addr[i] == req_addr_in)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[i];
            end
        end
    end

    // The LUTRAM port is gated by reset so it is quiet while reset is held.
    always_comb begin
        lutram_access_en_out     = 1'b0;
        lutram_write_en_out      = 1'b0;
        lutram_set_addr_out      = '0;
        lutram_write_element_out = '0;
        if (!reset_in) begin
            lutram_access_en_out = 1'b0;
        end else if (!in_run) begin
            lutram_access_en_out = 1'b1;
            lutram_write_en_out  = 1'b1;
            lutram_set_addr_out  = init_ptr;
        end else if (rd_accept) begin
            lutram_access_en_out = 1'b1;
            lutram_set_addr_out  = req_addr_in;
        end else if (wb_pop) begin
            lutram_access_en_out     = 1'b1;
            lutram_write_en_out      = 1'b1;
            lutram_set_addr_out      = wb_addr[0];
            lutram_write_element_out = wb_data[0];
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state          <= ST_INIT;
            init_ptr       <= '0;
            wb_count       <= '0;
            resp_valid_out <= 1'b0;
            resp_data_out  <= '0;
        end else begin
            if (!in_run) begin
                if (init_ptr == LAST_SET) begin
                    state <= ST_RUN;
                end else begin
                    init_ptr <= init_ptr + AW'(1);
                end
            end

            if (wr_accept && !wb_pop) begin
                wb_count <= wb_count + CNT_W'(1);
            end else if (!wr_accept && wb_pop) begin
                wb_count <= wb_count - CNT_W'(1);
            end

            if (rd_accept) begin
                resp_valid_out <= 1'b1;
                resp_data_out  <= fwd_hit ? fwd_data : lutram_read_element_in;
            end else if (resp_ready_in) begin
                resp_valid_out <= 1'b0;
            end
        end
    end

    // Buffer storage carries no reset; occupancy is defined by wb_count alone.
    always_ff @(posedge clk_in) begin
        if (wb_pop) begin
            for (int i = 0; i < WRITE_BUFFER_DEPTH - 1; i++) begin
                wb_addr[i] <= wb_addr[i+1];
                wb_data[i] <= wb_data[i+1];
            end
        end
        if (wr_accept) begin
            for (int i = 0; i < WRITE_BUFFER_DEPTH; i++) begin
                if (CNT_W'(i) == push_idx) begin
                    wb_addr[i] <= req_addr_in;
                    wb_data[i] <= req_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_lutram_access_ctrl.sv
// Bench for lutram_access_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of the posted-write buffer and memory.
module tb_lutram_access_ctrl;

    localparam int DW  = 64;
    localparam int NS  = 64;
    localparam int AW  = 6;
    localparam int WBD = 4;
    localparam int CW  = 3;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          req_valid_in;
    logic          req_ready_out;
    logic          req_write_in;
    logic [AW-1:0] req_addr_in;
    logic [DW-1:0] req_data_in;
    logic          resp_valid_out;
    logic          resp_ready_in;
    logic [DW-1:0] resp_data_out;
    logic          lutram_access_en_out;
    logic          lutram_write_en_out;
    logic [AW-1:0] lutram_set_addr_out;
    logic [DW-1:0] lutram_write_element_out;
    logic [DW-1:0] lutram_read_element_in;
    logic          init_done_out;
    logic [CW-1:0] wb_count_out;

    always #5 clk_in = ~clk_in;

    lutram_access_ctrl #(
        .SINGLE_ELEMENT_SIZE_IN_BITS(DW),
        .NUMBER_SETS(NS),
        .SET_PTR_WIDTH_IN_BITS(AW),
        .WRITE_BUFFER_DEPTH(WBD)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .req_valid_in(req_valid_in),
        .req_ready_out(req_ready_out),
        .req_write_in(req_write_in),
        .req_addr_in(req_addr_in),
        .req_data_in(req_data_in),
        .resp_valid_out(resp_valid_out),
        .resp_ready_in(resp_ready_in),
        .resp_data_out(resp_data_out),
        .lutram_access_en_out(lutram_access_en_out),
        .lutram_write_en_out(lutram_write_en_out),
        .lutram_set_addr_out(lutram_set_addr_out),
        .lutram_write_element_out(lutram_write_element_out),
        .lutram_read_element_in(lutram_read_element_in),
        .init_done_out(init_done_out),
        .wb_count_out(wb_count_out)
    );

    // Behavioural LUTRAM device: synchronous write, combinational read.
    logic [DW-1:0] lram [NS];
    always @(posedge clk_in) begin
        if (lutram_access_en_out && lutram_write_en_out)
            lram[lutram_set_addr_out] <= lutram_write_element_out;
    end
    assign lutram_read_element_in = lram[lutram_set_addr_out];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] ref_mem [NS];
    wr_t           q[$];

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic rr);
        req_valid_in  = v;
        req_write_in  = w;
        req_addr_in   = a;
        req_data_in   = d;
        resp_ready_in = rr;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        set_req(0, 0, '0, '0, 1);
        next_cycle();
        reset_in = 1'b0;
        #1;
        n_cmp++;
        if ({lutram_access_en_out, lutram_write_en_out, req_ready_out, resp_valid_out,
             init_done_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: en/we/rdy/rv/done=%b required 00000",
                     {lutram_access_en_out, lutram_write_en_out, req_ready_out,
                      resp_valid_out, init_done_out});
        end
        for (int i = 0; i < 3; i++) next_cycle();
        n_cmp++;
        if ({lutram_set_addr_out, lutram_write_element_out, resp_data_out, wb_count_out,
             lutram_access_en_out, init_done_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d wdata=%h rdata=%h cnt=%0d en=%b done=%b required all 0",
                     lutram_set_addr_out, lutram_write_element_out, resp_data_out,
                     wb_count_out, lutram_access_en_out, init_done_out);
        end
        reset_in = 1'b1;
    endtask

    // Called right after reset release; walks the full clear sweep.
    task automatic test_init_sweep();
        int bad;
        for (int k = 0; k < NS; k++) begin
            #1;
            n_cmp++;
            if ({lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
                 lutram_write_element_out, req_ready_out, init_done_out} !==
                {1'b1, 1'b1, AW'(k), DW'(0), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL sweep_cycle%0d: en=%b we=%b addr=%0d wd=%h rdy=%b done=%b required 1 1 %0d 0 0 0",
                         k, lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
                         lutram_write_element_out, req_ready_out, init_done_out, k);
            end
            next_cycle();
        end
        n_cmp++;
        if ({init_done_out, req_ready_out, wb_count_out} !== {1'b1, 1'b1, CW'(0)}) begin
            n_fail++;
            $display("FAIL sweep_done: done=%b rdy=%b cnt=%0d required 1 1 0",
                     init_done_out, req_ready_out, wb_count_out);
        end
        bad = 0;
        for (int i = 0; i < NS; i++) if (lram[i] !== '0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sweep_clear: %0d sets nonzero, required 0", bad);
        end
        for (int i = 0; i < NS; i++) ref_mem[i] = '0;
        q.delete();
    endtask

    task automatic test_forward();
        set_req(1, 1, 5, 64'hA5, 1);
        #1;
        n_cmp++;
        if ({req_ready_out, lutram_access_en_out} !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_wr: rdy/en=%b required 10", {req_ready_out, lutram_access_en_out});
        end
        next_cycle();
        set_req(1, 0, 5, '0, 1);
        #1;
        n_cmp++;
        if ({req_ready_out, lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
             wb_count_out} !== {1'b1, 1'b1, 1'b0, AW'(5), CW'(1)}) begin
            n_fail++;
            $display("FAIL fwd_rd_port: rdy=%b en=%b we=%b addr=%0d cnt=%0d required 1 1 0 5 1",
                     req_ready_out, lutram_access_en_out, lutram_write_en_out,
                     lutram_set_addr_out, wb_count_out);
        end
        next_cycle();
        set_req(0, 0, '0, '0, 1);
        n_cmp++;
        if ({resp_valid_out, resp_data_out} !== {1'b1, 64'hA5}) begin
            n_fail++;
            $display("FAIL fwd_data: valid=%b data=%h required 1 a5", resp_valid_out, resp_data_out);
        end
        #1;
        n_cmp++;
        if ({lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
             lutram_write_element_out} !== {1'b1, 1'b1, AW'(5), 64'hA5}) begin
            n_fail++;
            $display("FAIL fwd_pop: en=%b we=%b addr=%0d wd=%h required 1 1 5 a5",
                     lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
                     lutram_write_element_out);
        end
        next_cycle();
        n_cmp++;
        if ({wb_count_out, resp_valid_out, lram[5]} !== {CW'(0), 1'b0, 64'hA5}) begin
            n_fail++;
            $display("FAIL fwd_drain: cnt=%0d valid=%b mem5=%h required 0 0 a5",
                     wb_count_out, resp_valid_out, lram[5]);
        end
        ref_mem[5] = 64'hA5;
    endtask

    task automatic test_same_addr();
        set_req(1, 1, 7, 64'h1, 1);
        next_cycle();
        set_req(1, 1, 7, 64'h2, 1);
        #1;
        n_cmp++;
        if ({lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
             lutram_write_element_out} !== {1'b1, 1'b1, AW'(7), 64'h1}) begin
            n_fail++;
            $display("FAIL same_pop1: en=%b we=%b addr=%0d wd=%h required 1 1 7 1",
                     lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
                     lutram_write_element_out);
        end
        next_cycle();
        n_cmp++;
        if (wb_count_out !== CW'(1)) begin
            n_fail++;
            $display("FAIL same_cnt: cnt=%0d required 1", wb_count_out);
        end
        set_req(1, 0, 7, '0, 1);
        next_cycle();
        set_req(0, 0, '0, '0, 1);
        n_cmp++;
        if ({resp_valid_out, resp_data_out} !== {1'b1, 64'h2}) begin
            n_fail++;
            $display("FAIL same_fwd: valid=%b data=%h required 1 2", resp_valid_out, resp_data_out);
        end
        next_cycle();
        n_cmp++;
        if ({wb_count_out, lram[7]} !== {CW'(0), 64'h2}) begin
            n_fail++;
            $display("FAIL same_drain: cnt=%0d mem7=%h required 0 2", wb_count_out, lram[7]);
        end
        ref_mem[7] = 64'h2;
    endtask

    task automatic test_backpressure();
        set_req(1, 0, 5, '0, 0);
        #1;
        n_cmp++;
        if (req_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_rdy: rdy=%b required 1", req_ready_out);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 0, 7, '0, 0);
            #1;
            n_cmp++;
            if ({resp_valid_out, resp_data_out, req_ready_out, lutram_access_en_out} !==
                {1'b1, 64'hA5, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%h rdy=%b en=%b required 1 a5 0 0",
                         i, resp_valid_out, resp_data_out, req_ready_out, lutram_access_en_out);
            end
            next_cycle();
        end
        set_req(1, 0, 7, '0, 1);
        #1;
        n_cmp++;
        if ({req_ready_out, lutram_access_en_out, lutram_set_addr_out} !== {1'b1, 1'b1, AW'(7)}) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b en=%b addr=%0d required 1 1 7",
                     req_ready_out, lutram_access_en_out, lutram_set_addr_out);
        end
        next_cycle();
        set_req(0, 0, '0, '0, 1);
        n_cmp++;
        if ({resp_valid_out, resp_data_out} !== {1'b1, 64'h2}) begin
            n_fail++;
            $display("FAIL bp_reload: valid=%b data=%h required 1 2", resp_valid_out, resp_data_out);
        end
        next_cycle();
        n_cmp++;
        if (resp_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_consumed: valid=%b required 0", resp_valid_out);
        end
    endtask

    task automatic test_back_to_back();
        set_req(1, 1, 9, 64'h99, 1);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            set_req(1, 0, 9, '0, 1);
            #1;
            n_cmp++;
            if ({req_ready_out, lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out} !==
                {1'b1, 1'b1, 1'b0, AW'(9)}) begin
                n_fail++;
                $display("FAIL b2b_port%0d: rdy=%b en=%b we=%b addr=%0d required 1 1 0 9",
                         i, req_ready_out, lutram_access_en_out, lutram_write_en_out,
                         lutram_set_addr_out);
            end
            next_cycle();
            n_cmp++;
            if ({resp_valid_out, resp_data_out, wb_count_out} !== {1'b1, 64'h99, CW'(1)}) begin
                n_fail++;
                $display("FAIL b2b_resp%0d: valid=%b data=%h cnt=%0d required 1 99 1",
                         i, resp_valid_out, resp_data_out, wb_count_out);
            end
        end
        set_req(0, 0, '0, '0, 1);
        #1;
        n_cmp++;
        if ({lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
             lutram_write_element_out} !== {1'b1, 1'b1, AW'(9), 64'h99}) begin
            n_fail++;
            $display("FAIL b2b_pop: en=%b we=%b addr=%0d wd=%h required 1 1 9 99",
                     lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
                     lutram_write_element_out);
        end
        next_cycle();
        n_cmp++;
        if ({wb_count_out, resp_valid_out} !== {CW'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_drain: cnt=%0d valid=%b required 0 0", wb_count_out, resp_valid_out);
        end
        ref_mem[9] = 64'h99;
    endtask

    task automatic test_random();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic          v, w, rr, exp_rdy, acc, rd, pop, hit, e_en, e_we;
        logic [AW-1:0] a, e_addr;
        logic [DW-1:0] d, e_wd;
        int            bad;
        exp_v = 1'b0;
        exp_d = '0;
        for (int c = 0; c < 400; c++) begin
            n_cmp++;
            if ((resp_valid_out !== exp_v) || (exp_v && (resp_data_out !== exp_d)) ||
                (wb_count_out !== CW'(q.size()))) begin
                n_fail++;
                $display("FAIL rnd_state c%0d: valid=%b data=%h cnt=%0d required %b %h %0d",
                         c, resp_valid_out, resp_data_out, wb_count_out, exp_v, exp_d, q.size());
            end
            v  = (c < 390) && ($urandom_range(0, 9) < 7);
            w  = $urandom_range(0, 1) == 1;
            a  = AW'($urandom_range(0, 15));
            d  = {$urandom, $urandom};
            rr = $urandom_range(0, 3) != 0;
            set_req(v, w, a, d, rr);
            #1;
            exp_rdy = (q.size() < WBD) && !(exp_v && !rr);
            n_cmp++;
            if (req_ready_out !== exp_rdy) begin
                n_fail++;
                $display("FAIL rnd_ready c%0d: rdy=%b required %b", c, req_ready_out, exp_rdy);
            end
            acc    = v && exp_rdy;
            rd     = acc && !w;
            pop    = !rd && (q.size() > 0);
            e_en   = rd || pop;
            e_we   = pop;
            e_addr = rd ? a : (pop ? q[0].a : '0);
            e_wd   = pop ? q[0].d : '0;
            n_cmp++;
            if ((lutram_access_en_out !== e_en) || (lutram_write_en_out !== e_we) ||
                (e_en && (lutram_set_addr_out !== e_addr)) ||
                (e_we && (lutram_write_element_out !== e_wd))) begin
                n_fail++;
                $display("FAIL rnd_port c%0d: en=%b we=%b addr=%0d wd=%h required %b %b %0d %h",
                         c, lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
                         lutram_write_element_out, e_en, e_we, e_addr, e_wd);
            end
            if (rd) begin
                hit = 1'b0;
                for (int i = q.size() - 1; i >= 0 && !hit; i--) begin
                    if (q[i].a == a) begin
                        hit   = 1'b1;
                        exp_d = q[i].d;
                    end
                end
                if (!hit) exp_d = ref_mem[a];
                exp_v = 1'b1;
            end else if (rr) begin
                exp_v = 1'b0;
            end
            if (pop) begin
                ref_mem[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (acc && w) q.push_back('{a: a, d: d});
            next_cycle();
        end
        n_cmp++;
        if (q.size() != 0 || wb_count_out !== CW'(0)) begin
            n_fail++;
            $display("FAIL rnd_drain: cnt=%0d model=%0d required 0", wb_count_out, q.size());
        end
        bad = 0;
        for (int i = 0; i < NS; i++) if (lram[i] !== ref_mem[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rnd_memory: %0d sets differ, required 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        set_req(1, 1, 3, 64'h33, 1);
        next_cycle();
        set_req(0, 0, '0, '0, 1);
        reset_in = 1'b0;
        #1;
        n_cmp++;
        if ({wb_count_out, init_done_out, req_ready_out, lutram_access_en_out} !==
            {CW'(0), 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL run_reset: cnt=%0d done=%b rdy=%b en=%b required 0 0 0 0",
                     wb_count_out, init_done_out, req_ready_out, lutram_access_en_out);
        end
        next_cycle();
        reset_in = 1'b1;
        for (int i = 0; i < 20; i++) next_cycle();
        #1;
        n_cmp++;
        if ({lutram_access_en_out, lutram_set_addr_out} !== {1'b1, AW'(20)}) begin
            n_fail++;
            $display("FAIL sweep_at20: en=%b addr=%0d required 1 20",
                     lutram_access_en_out, lutram_set_addr_out);
        end
        reset_in = 1'b0;
        #1;
        n_cmp++;
        if ({lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
             req_ready_out, init_done_out, resp_valid_out, wb_count_out} !== '0) begin
            n_fail++;
            $display("FAIL sweep_reset: en=%b we=%b addr=%0d rdy=%b done=%b rv=%b cnt=%0d required all 0",
                     lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
                     req_ready_out, init_done_out, resp_valid_out, wb_count_out);
        end
        next_cycle();
        next_cycle();
        reset_in = 1'b1;
        test_init_sweep();
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_forward();
        test_same_addr();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
